// File: rtl/lu_rr_arbiter_if.sv
// Requester/logic-unit bus of lu_rr_arbiter; slave = arbiter side, master = requesters + logic unit.
// Optional LU_ARB_STATS_EN adds the per-requester grant counters.
interface lu_rr_arbiter_if #(
  parameter int W    = 4,
  parameter int SELW = 3
);
  logic            req0;
  logic [W-1:0]    a0;
  logic [W-1:0]    b0;
  logic [SELW-1:0] sel0;
  logic            req1;
  logic [W-1:0]    a1;
  logic [W-1:0]    b1;
  logic [SELW-1:0] sel1;
  logic            done0;
  logic            res0;
  logic            done1;
  logic            res1;
  logic [W-1:0]    lu_a;
  logic [W-1:0]    lu_b;
  logic [SELW-1:0] lu_sel;
  logic            lu_out;
  logic            busy;
`ifdef LU_ARB_STATS_EN
  logic [7:0]      gnt_cnt0;
  logic [7:0]      gnt_cnt1;

  modport slave (
    input  req0, a0, b0, sel0, req1, a1, b1, sel1, lu_out,
    output done0, res0, done1, res1, lu_a, lu_b, lu_sel, busy, gnt_cnt0, gnt_cnt1
  );
  modport master (
    output req0, a0, b0, sel0, req1, a1, b1, sel1, lu_out,
    input  done0, res0, done1, res1, lu_a, lu_b, lu_sel, busy, gnt_cnt0, gnt_cnt1
  );
`else
  modport slave (
    input  req0, a0, b0, sel0, req1, a1, b1, sel1, lu_out,
    output done0, res0, done1, res1, lu_a, lu_b, lu_sel, busy
  );
  modport master (
    output req0, a0, b0, sel0, req1, a1, b1, sel1, lu_out,
    input  done0, res0, done1, res1, lu_a, lu_b, lu_sel, busy
  );
`endif
endinterface

// File: rtl/lu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational logic unit between two requesters.
// Optional macro LU_ARB_STATS_EN adds 8-bit wrapping grant counters gnt_cnt0/gnt_cnt1.
//
// state | meaning
// IDLE  | waiting for a request; arbitration happens here only
// ISSUE | lu_* registered and stable, lu_out settling
// RESP  | done pulse of the granted requester is high
module lu_rr_arbiter #(
  parameter int W    = 4,
  parameter int SELW = 3
) (
  input logic             clk,
  input logic             rst_n,
  lu_rr_arbiter_if.slave  bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic [W-1:0]    lu_a_q, lu_a_d;
  logic [W-1:0]    lu_b_q, lu_b_d;
  logic [SELW-1:0] lu_sel_q, lu_sel_d;
  logic            done0_q, done0_d;
  logic            done1_q, done1_d;
  logic            res0_q, res0_d;
  logic            res1_q, res1_d;
  logic            win;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    lu_a_d       = lu_a_q;
    lu_b_d       = lu_b_q;
    lu_sel_d     = lu_sel_q;
    res0_d       = res0_q;
    res1_d       = res1_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    // Contention goes to whoever was not served last; a lone request always wins.
    win          = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
    case (state_q)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_d  = win;
          lu_a_d   = win ? bus.a1   : bus.a0;
          lu_b_d   = win ? bus.b1   : bus.b0;
          lu_sel_d = win ? bus.sel1 : bus.sel0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (grant_q) begin
          res1_d  = bus.lu_out;
          done1_d = 1'b1;
        end else begin
          res0_d  = bus.lu_out;
          done0_d = 1'b1;
        end
        last_grant_d = grant_q;
        state_d      = ST_RESP;
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      lu_a_q       <= '0;
      lu_b_q       <= '0;
      lu_sel_q     <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      res0_q       <= 1'b0;
      res1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      lu_a_q       <= lu_a_d;
      lu_b_q       <= lu_b_d;
      lu_sel_q     <= lu_sel_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
    end
  end

  assign bus.lu_a   = lu_a_q;
  assign bus.lu_b   = lu_b_q;
  assign bus.lu_sel = lu_sel_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.res0   = res0_q;
  assign bus.res1   = res1_q;
  assign bus.busy   = (state_q != ST_IDLE);

`ifdef LU_ARB_STATS_EN
  logic [7:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [7:0] gnt_cnt1_q, gnt_cnt1_d;

  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (state_q == ST_ISSUE) begin
      if (grant_q) gnt_cnt1_d = gnt_cnt1_q + 8'd1;
      else         gnt_cnt0_d = gnt_cnt0_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_q <= 8'd0;
      gnt_cnt1_q <= 8'd0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign bus.gnt_cnt0 = gnt_cnt0_q;
  assign bus.gnt_cnt1 = gnt_cnt1_q;
`endif
endmodule
